score_bcd_sched: RTL and testbench

Sequential score keeper and scheduler for the game's score datapath. It counts scoring events, saturates at a maximum, and converts the binary score to BCD with a multi-cycle shift-add-3 engine. It re-runs the conversion whenever the score changes during a conversion, so the display path always settles to the current score. It sits between the game FSM (`game_status`, `add_cube`) and the 7-segment digit driver.

---
 rtl/game_pkg.sv | 18 +
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/score_bcd_sched.sv | 87 ++++++++
 tb/tb_score_bcd_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: status encoding, BCD engine states, nibble width.
// Used by the score path and its BCD conversion engine.
package game_pkg;

   localparam logic [1:0] GS_RESTART = 2'b00;
   localparam logic [1:0] GS_PLAY    = 2'b01;
   localparam logic [1:0] GS_PAUSE   = 2'b10;
   localparam logic [1:0] GS_OVER    = 2'b11;

   localparam int BCD_NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ENG_IDLE  = 2'b00,
      ENG_SHIFT = 2'b01,
      ENG_DONE  = 2'b10
   } eng_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD engine, one bit per cycle.
// start is accepted in IDLE only; done is high for the DONE cycle.
module bin2bcd_seq
   import game_pkg::*;
#(
   parameter int W      = 8,
   parameter int DIGITS = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [W-1:0]                 bin_in,
   output logic                         busy,
   output logic                         idle,
   output logic                         done,
   output logic [W-1:0]                 conv_bin,
   output logic [BCD_NIBBLE_W*DIGITS-1:0] acc,
   output logic [BCD_NIBBLE_W*DIGITS-1:0] bcd_data
);

   localparam int AW = BCD_NIBBLE_W * DIGITS;
   localparam int CW = $clog2(W) + 1;

   eng_state_t       state;
   logic [W-1:0]     sh;
   logic [CW-1:0]    cnt;
   logic [AW-1:0]    acc_adj;
   logic [AW+W-1:0]  cat;

   assign busy = (state != ENG_IDLE);
   assign idle = (state == ENG_IDLE);
   assign done = (state == ENG_DONE);

   // Add-3 correction of every nibble >= 5 ahead of the shift
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] >= 4'd5)
            acc_adj[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] =
               acc[i*BCD_NIBBLE_W +: BCD_NIBBLE_W] + 4'd3;
      end
      cat = {acc_adj, sh} << 1;
   end

   // Engine FSM: load, W shift steps, publish result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ENG_IDLE;
         sh       <= '0;
         cnt      <= '0;
         acc      <= '0;
         conv_bin <= '0;
         bcd_data <= '0;
      end else begin
         unique case (state)
            ENG_IDLE: begin
               if (start) begin
                  sh       <= bin_in;
                  conv_bin <= bin_in;
                  acc      <= '0;
                  cnt      <= '0;
                  state    <= ENG_SHIFT;
               end
            end
            ENG_SHIFT: begin
               acc <= cat[AW+W-1:W];
               sh  <= cat[W-1:0];
               cnt <= cnt + CW'(1);
               if (cnt == CW'(W - 1))
                  state <= ENG_DONE;
            end
            ENG_DONE: begin
               bcd_data <= acc;
               state    <= ENG_IDLE;
            end
            default: state <= ENG_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/score_bcd_sched.sv
// Score keeper with saturation and coalescing BCD reconversion scheduler.
// Optional high-score tracking enabled by defining SCORE_HISCORE_EN.
module score_bcd_sched
   import game_pkg::*;
#(
   parameter int SCORE_W   = 8,
   parameter int SCORE_MAX = 100,
   parameter int DIGITS    = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            game_status,
   input  logic                  add_cube,
   output logic [SCORE_W-1:0]    score_bin,
   output logic [4*DIGITS-1:0]   bcd_data,
   output logic                  bcd_valid,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   hi_bcd
);

   localparam int BW = BCD_NIBBLE_W * DIGITS;

   logic               dirty;
   logic               start;
   logic               can_add;
   logic               eng_idle;
   logic               eng_done;
   logic [SCORE_W-1:0] conv_bin;
   logic [BW-1:0]      bcd_acc;

   assign can_add   = (game_status == GS_PLAY) && add_cube &&
                      (score_bin < SCORE_W'(SCORE_MAX));
   assign start     = eng_idle && dirty;
   assign bcd_valid = eng_idle && !dirty;

   // Score register; any change re-arms dirty even if a load happens now
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_bin <= '0;
         dirty     <= 1'b0;
      end else if (game_status == GS_RESTART) begin
         score_bin <= '0;
         dirty     <= 1'b1;
      end else if (can_add) begin
         score_bin <= score_bin + SCORE_W'(1);
         dirty     <= 1'b1;
      end else if (start) begin
         dirty     <= 1'b0;
      end
   end

   bin2bcd_seq #(
      .W      (SCORE_W),
      .DIGITS (DIGITS)
   ) u_eng (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin_in   (score_bin),
      .busy     (busy),
      .idle     (eng_idle),
      .done     (eng_done),
      .conv_bin (conv_bin),
      .acc      (bcd_acc),
      .bcd_data (bcd_data)
   );

`ifdef SCORE_HISCORE_EN
   logic [SCORE_W-1:0] hi_bin;

   // Capture a new high score when a conversion completes above it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_bin <= '0;
         hi_bcd <= '0;
      end else if (eng_done && (conv_bin > hi_bin)) begin
         hi_bin <= conv_bin;
         hi_bcd <= bcd_acc;
      end
   end
`else
   logic unused_hs;
   assign unused_hs = ^{eng_done, conv_bin, bcd_acc};
   assign hi_bcd    = '0;
`endif

endmodule

// File: tb/tb_score_bcd_sched.sv
// Scoreboard bench for score_bcd_sched: expected conversions queued at
// stimulus time, popped by a monitor on each bcd_valid rise.
module tb_score_bcd_sched;
   import game_pkg::*;

`ifdef SCORE_HISCORE_EN
   localparam bit HS = 1'b1;
`else
   localparam bit HS = 1'b0;
`endif

   typedef struct {
      logic [7:0]  score;
      logic [11:0] bcd;
      logic [11:0] hi;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  game_status;
   logic        add_cube;
   logic [7:0]  score_bin;
   logic [11:0] bcd_data;
   logic        bcd_valid;
   logic        busy;
   logic [11:0] hi_bcd;

   exp_t q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic prev_valid = 1'b1;
   int   n;

   score_bcd_sched #(
      .SCORE_W   (8),
      .SCORE_MAX (100),
      .DIGITS    (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .game_status (game_status),
      .add_cube    (add_cube),
      .score_bin   (score_bin),
      .bcd_data    (bcd_data),
      .bcd_valid   (bcd_valid),
      .busy        (busy),
      .hi_bcd      (hi_bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      r[11:8] = 4'((v / 100) % 10);
      r[7:4]  = 4'((v / 10) % 10);
      r[3:0]  = 4'(v % 10);
      return r;
   endfunction

   task automatic push(input int s, input int h);
      exp_t e;
      e.score = 8'(s);
      e.bcd   = to_bcd(s);
      e.hi    = HS ? to_bcd(h) : 12'h000;
      q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic pulse;
      add_cube = 1'b1;
      tick();
      add_cube = 1'b0;
   endtask

   task automatic wait_valid(input string name, input int budget,
                             output int cnt);
      cnt = 0;
      while (!bcd_valid && cnt < budget) begin
         tick();
         cnt++;
      end
      check(name, {31'd0, bcd_valid}, 32'd1);
   endtask

   task automatic do_reset;
      rst_n       = 1'b0;
      add_cube    = 1'b0;
      game_status = GS_PLAY;
      repeat (3) tick();
      q.delete();
      rst_n = 1'b1;
      tick();
   endtask

   // Monitor: each rising bcd_valid must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bcd_valid && !prev_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_conv: bcd %0h score %0d, none expected",
                     bcd_data, score_bin);
         end else begin
            mon_e = q.pop_front();
            check("mon_bcd", 32'(bcd_data), 32'(mon_e.bcd));
            check("mon_score", 32'(score_bin), 32'(mon_e.score));
            check("mon_hi", 32'(hi_bcd), 32'(mon_e.hi));
         end
      end
      prev_valid = bcd_valid;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      add_cube    = 1'b0;
      game_status = GS_PLAY;
      repeat (2) tick();
      check("rst_score", 32'(score_bin), 0);
      check("rst_bcd", 32'(bcd_data), 0);
      check("rst_hi", 32'(hi_bcd), 0);
      check("rst_valid", {31'd0, bcd_valid}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      rst_n = 1'b1;
      tick();

      // single pulse latency
      push(1, 1);
      pulse();
      check("t1_score_e0", 32'(score_bin), 1);
      check("t1_busy_e0", {31'd0, busy}, 0);
      check("t1_valid_e0", {31'd0, bcd_valid}, 0);
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("t1_busy", {31'd0, busy}, 1);
      end
      tick();
      check("t1_bcd_e10", 32'(bcd_data), 32'h001);
      check("t1_busy_e10", {31'd0, busy}, 0);
      check("t1_valid_e10", {31'd0, bcd_valid}, 1);
      tick();
      check("t1_drain", q.size(), 0);

      // three consecutive pulses coalesce into one reconversion
      do_reset();
      push(3, 3);
      add_cube = 1'b1;
      repeat (3) tick();
      add_cube = 1'b0;
      check("t3_score", 32'(score_bin), 3);
      wait_valid("t3_timeout", 60, n);
      check("t3_latency", n, 18);
      check("t3_bcd", 32'(bcd_data), 32'h003);
      repeat (15) tick();
      check("t3_busy_after", {31'd0, busy}, 0);
      check("t3_drain", q.size(), 0);

      // RESTART during SHIFT cycle 4 of the 42 conversion
      do_reset();
      push(41, 41);
      add_cube = 1'b1;
      repeat (41) tick();
      add_cube = 1'b0;
      wait_valid("t5_timeout41", 40, n);
      check("t5_score41", 32'(score_bin), 41);
      push(0, 42);
      pulse();
      check("t5_score42", 32'(score_bin), 42);
      repeat (4) tick();
      check("t5_busy_shift", {31'd0, busy}, 1);
      game_status = GS_RESTART;
      tick();
      game_status = GS_PLAY;
      check("t5_score_clr", 32'(score_bin), 0);
      repeat (5) tick();
      check("t5_bcd_42", 32'(bcd_data), 32'h042);
      check("t5_valid_42", {31'd0, bcd_valid}, 0);
      check("t5_hi_42", 32'(hi_bcd), HS ? 32'h042 : 32'h000);
      wait_valid("t5_timeout0", 30, n);
      check("t5_bcd_0", 32'(bcd_data), 32'h000);
      tick();
      check("t5_drain", q.size(), 0);

      // score 57, then PAUSE / OVER pulses are ignored
      do_reset();
      push(57, 57);
      add_cube = 1'b1;
      repeat (57) tick();
      add_cube = 1'b0;
      wait_valid("t4_timeout", 40, n);
      game_status = GS_PAUSE;
      for (int k = 0; k < 3; k++) begin
         pulse();
         tick();
      end
      repeat (12) tick();
      check("t4_pause_score", 32'(score_bin), 57);
      check("t4_pause_bcd", 32'(bcd_data), 32'h057);
      check("t4_pause_busy", {31'd0, busy}, 0);
      check("t4_pause_valid", {31'd0, bcd_valid}, 1);
      game_status = GS_OVER;
      pulse();
      repeat (12) tick();
      check("t4_over_score", 32'(score_bin), 57);
      check("t4_over_busy", {31'd0, busy}, 0);
      check("t4_drain", q.size(), 0);

      // asynchronous reset at SHIFT cycle 3
      game_status = GS_PLAY;
      pulse();
      repeat (3) tick();
      check("t6_busy_pre", {31'd0, busy}, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_score", 32'(score_bin), 0);
      check("t6_bcd", 32'(bcd_data), 0);
      check("t6_busy", {31'd0, busy}, 0);
      check("t6_valid", {31'd0, bcd_valid}, 1);
      check("t6_hi", 32'(hi_bcd), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // 105 spaced pulses saturate at 100
      do_reset();
      for (int k = 1; k <= 105; k++) begin
         if (k <= 100)
            push(k, k);
         pulse();
         repeat (11) tick();
      end
      check("t2_score", 32'(score_bin), 100);
      check("t2_bcd", 32'(bcd_data), 32'h100);
      check("t2_valid", {31'd0, bcd_valid}, 1);
      check("t2_busy", {31'd0, busy}, 0);
      check("t2_hi", 32'(hi_bcd), HS ? 32'h100 : 32'h000);
      check("t2_drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
